// File: rtl/fifo_operand_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fifo_mult_pkg                                                  |
// | Shared FSM state encoding and the counter-width helper for the FIFO      |
// | operand multiplier.                                                      |
// | No ports (package).                                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package fifo_mult_pkg;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    WAIT_A  = 3'd1,
    FETCH_B = 3'd2,
    WAIT_B  = 3'd3,
    MULT    = 3'd4,
    OUT     = 3'd5
  } state_t;

  // Bit count needed to index every operand bit (0 .. width-1).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_operand_mult_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : fifo_operand_mult_if                                         |
// | Groups the FIFO read side and the product valid/ready port.              |
// |   fifo_empty_n : FIFO has data (1 = not empty)                           |
// |   fifo_data    : FIFO read data, valid the cycle after fifo_read         |
// |   fifo_read    : read strobe towards the FIFO                            |
// |   prod         : 2*WIDTH unsigned product                                |
// |   prod_valid   : product valid, held until accepted                      |
// |   prod_ready   : sink ready                                              |
// | master = multiplier side, slave = FIFO/sink side.                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface fifo_operand_mult_if #(
  parameter int WIDTH = 8
);
  logic                 fifo_empty_n;
  logic [WIDTH-1:0]     fifo_data;
  logic                 fifo_read;
  logic [2*WIDTH-1:0]   prod;
  logic                 prod_valid;
  logic                 prod_ready;

  modport master (
    input  fifo_empty_n,
    input  fifo_data,
    input  prod_ready,
    output fifo_read,
    output prod,
    output prod_valid
  );

  modport slave (
    output fifo_empty_n,
    output fifo_data,
    output prod_ready,
    input  fifo_read,
    input  prod,
    input  prod_valid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_operand_mult_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : shift_add_core                                                  |
// | Sequential shift-add multiplier, one operand bit per cycle, WIDTH cycles |
// | after start.                                                             |
// |   clock, reset_n (async), clear_n (sync)                                 |
// |   start   : load acc/cnt with zero and begin (a, b must be held stable)  |
// |   a, b    : unsigned operands                                            |
// |   done    : high in the last multiply cycle                              |
// |   product : final product, valid while done is high                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module shift_add_core
  import fifo_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  input  wire logic                 clear_n,
  input  wire logic                 start,
  input  wire logic [WIDTH-1:0]     a,
  input  wire logic [WIDTH-1:0]     b,
  output logic                      done,
  output logic [2*WIDTH-1:0]        product
);

  localparam int              CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic               running;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  // The running sum including the current bit; in the last cycle this is the
  // finished product, so it is exported directly rather than one cycle late.
  always_comb begin
    a_ext    = {{WIDTH{1'b0}}, a};
    addend   = b[cnt] ? (a_ext << cnt) : '0;
    acc_next = acc + addend;
  end

  assign done    = running && (cnt == C_LAST);
  assign product = acc_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      running <= 1'b0;
    end else if (!clear_n) begin
      cnt     <= '0;
      acc     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      acc     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc <= acc_next;
      if (done) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_operand_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fifo_operand_mult                                               |
// | Pops operand pairs (A then B) from a FIFO, multiplies them with a        |
// | shift-add core and presents the product on a valid/ready port.           |
// |   clock   : rising-edge clock                                            |
// |   reset_n : asynchronous active-low reset                                |
// |   clear_n : synchronous active-low clear (same effect as reset)          |
// |   io      : fifo_operand_mult_if.master (FIFO read side + product port)  |
// |   busy    : 1 in every state except FETCH_A                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_operand_mult
  import fifo_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             clear_n,
  fifo_operand_mult_if.master   io,
  output logic                  busy
);

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic                 prod_valid_reg;
  logic                 core_start;
  logic                 core_done;
  logic [2*WIDTH-1:0]   core_product;

  // Read strobe is gated by reset and clear so no operand is popped from the
  // FIFO in a cycle whose result is about to be discarded.
  assign io.fifo_read = reset_n && clear_n && io.fifo_empty_n &&
                        ((state == FETCH_A) || (state == FETCH_B));

  assign io.prod       = prod_reg;
  assign io.prod_valid = prod_valid_reg;
  assign core_start    = (state == WAIT_B);

  shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_n (clear_n),
    .start   (core_start),
    .a       (a_reg),
    .b       (b_reg),
    .done    (core_done),
    .product (core_product)
  );

  // busy is registered from the next state so it equals (state != FETCH_A).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FETCH_A;
      a_reg          <= '0;
      b_reg          <= '0;
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      busy           <= 1'b0;
    end else if (!clear_n) begin
      state          <= FETCH_A;
      a_reg          <= '0;
      b_reg          <= '0;
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        FETCH_A: begin
          if (io.fifo_empty_n) begin
            state <= WAIT_A;
            busy  <= 1'b1;
          end
        end
        WAIT_A: begin
          a_reg <= io.fifo_data;
          state <= FETCH_B;
        end
        FETCH_B: begin
          if (io.fifo_empty_n) begin
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          b_reg <= io.fifo_data;
          state <= MULT;
        end
        MULT: begin
          if (core_done) begin
            prod_reg       <= core_product;
            prod_valid_reg <= 1'b1;
            state          <= OUT;
          end
        end
        OUT: begin
          if (io.prod_ready) begin
            prod_valid_reg <= 1'b0;
            busy           <= 1'b0;
            state          <= FETCH_A;
          end
        end
        default: begin
          state <= FETCH_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_operand_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fifo_operand_mult                                            |
// | Scoreboard bench: behavioural FIFO upstream, expected products queued    |
// | at stimulus time and compared by a monitor on each accepted product.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_operand_mult;

  localparam int WIDTH = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic clear_n = 1'b1;
  logic busy;

  fifo_operand_mult_if #(.WIDTH(WIDTH)) io ();

  fifo_operand_mult #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_n (clear_n),
    .io      (io.master),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural FIFO (data valid the cycle after read) ----
  logic       push_en   = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fmem[$];
  logic [7:0] fdata     = 8'h00;
  logic       fempty_n  = 1'b0;

  assign io.fifo_data    = fdata;
  assign io.fifo_empty_n = fempty_n;

  always @(posedge clock) begin
    if (io.fifo_read && fmem.size() != 0) fdata <= fmem.pop_front();
    if (push_en) fmem.push_back(push_data);
    fempty_n <= (fmem.size() != 0);
  end

  // ---------------- product-ready source ----------------------------------
  logic ready_dir = 1'b1;
  logic rand_mode = 1'b0;
  logic ready_rnd = 1'b1;
  assign io.prod_ready = rand_mode ? ready_rnd : ready_dir;

  always @(posedge clock) begin
    #1;
    ready_rnd = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard state --------------------------------------
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t_a_read = 0;
  int          last_rise = -1;
  bit          lat_chk  = 1'b1;
  bit          b2b_chk  = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_prod  = 16'h0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_timeout(input string name, input int waited);
    checks++;
    failures++;
    $display("FAIL timeout_%s: waited=%0d cycles, required event never occurred", name, waited);
  endtask

  task automatic monitor();
    logic rise;
    forever begin
      @(negedge clock);
      cyc++;
      if (io.fifo_read) chk("read_while_nonempty", io.fifo_empty_n, 1);
      if (io.fifo_read && !busy) t_a_read = cyc;
      rise = io.prod_valid && !prev_valid;
      if (rise) begin
        if (lat_chk) chk("latency", cyc - t_a_read, WIDTH + 4);
        if (b2b_chk && last_rise >= 0) chk("b2b_interval", cyc - last_rise, WIDTH + 5);
        last_rise = cyc;
      end
      if (prev_valid && !prev_ready && reset_n && clear_n) begin
        chk("hold_valid", io.prod_valid, 1);
        chk("hold_prod", io.prod, prev_prod);
      end
      if (io.prod_valid && io.prod_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_product: actual=0x%0h required=none", io.prod);
        end else begin
          chk("product", io.prod, exp_q.pop_front());
        end
      end
      prev_valid = io.prod_valid;
      prev_ready = io.prod_ready;
      prev_prod  = io.prod;
    end
  endtask

  // ---------------- stimulus helpers (align to posedge + 1) ---------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_en   = 1'b1;
    push_data = b;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    exp_q.push_back(e);
    push(a);
    push(b);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!io.prod_valid && n < max) begin
      tick();
      n++;
    end
    if (!io.prod_valid) fail_timeout(name, n);
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || io.prod_valid) && n < max) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || io.prod_valid) fail_timeout(name, n);
  endtask

  task automatic wait_fetch_b(input string name);
    int n;
    n = 0;
    while (!(io.fifo_read && busy) && n < 50) begin
      tick();
      n++;
    end
    if (!(io.fifo_read && busy)) fail_timeout(name, n);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] re;
    fork
      monitor();
    join_none

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_prod_valid", io.prod_valid, 0);
    chk("reset_prod", io.prod, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_read", io.fifo_read, 0);
    reset_n = 1'b1;
    tick();

    // 1. 3 * 5, valid for exactly one cycle
    push_pair(8'h03, 8'h05, 16'h000F);
    wait_valid("t1", 40);
    tick();
    chk("t1_valid_one_cycle", io.prod_valid, 0);
    chk("t1_prod_kept", io.prod, 16'h000F);
    drain("t1", 40);

    // 2. Extremes back to back
    last_rise = -1;
    b2b_chk   = 1'b1;
    push_pair(8'hFF, 8'hFF, 16'hFE01);
    push_pair(8'h00, 8'hA7, 16'h0000);
    drain("t2", 80);
    b2b_chk   = 1'b0;
    chk("t2_last_prod", io.prod, 16'h0000);

    // 3. Odd operand: stall in FETCH_B
    lat_chk = 1'b0;
    exp_q.push_back(16'h0084);
    push(8'h0C);
    repeat (20) tick();
    chk("t3_stall_fifo_read", io.fifo_read, 0);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_valid", io.prod_valid, 0);
    push(8'h0B);
    drain("t3", 60);
    lat_chk = 1'b1;

    // 4. Back-pressure: no reads while the product is held
    ready_dir = 1'b0;
    push_pair(8'h07, 8'h09, 16'h003F);
    push_pair(8'h02, 8'h03, 16'h0006);
    wait_valid("t4", 40);
    repeat (10) begin
      tick();
      chk("t4_no_read", io.fifo_read, 0);
      chk("t4_prod", io.prod, 16'h003F);
    end
    ready_dir = 1'b1;
    drain("t4", 80);

    // 5. Asynchronous reset during MULT
    push_pair(8'h11, 8'h22, 16'h0242);
    wait_fetch_b("t5");
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("t5_rst_prod_valid", io.prod_valid, 0);
    chk("t5_rst_prod", io.prod, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_fifo_read", io.fifo_read, 0);
    void'(exp_q.pop_back());
    tick();
    reset_n = 1'b1;
    push_pair(8'h0D, 8'h0E, 16'h00B6);
    drain("t5", 60);

    // 5b. Synchronous clear during MULT
    push_pair(8'h21, 8'h03, 16'h0063);
    wait_fetch_b("t5b");
    repeat (3) tick();
    clear_n = 1'b0;
    tick();
    chk("t5b_clr_prod_valid", io.prod_valid, 0);
    chk("t5b_clr_prod", io.prod, 0);
    chk("t5b_clr_busy", busy, 0);
    void'(exp_q.pop_back());
    clear_n = 1'b1;
    push_pair(8'h10, 8'h10, 16'h0100);
    drain("t5b", 60);

    // 6. 32 random pairs with random ready
    rand_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      re = 16'(ra) * 16'(rb);
      push_pair(ra, rb, re);
    end
    drain("t6", 3000);
    rand_mode = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
